// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg : opcode, flag-index and FSM state definitions for alu_mc
// Rev 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_INC  = 4'h5,
    OP_MOVA = 4'h6,
    OP_MOVB = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_ASR  = 4'hA,
    OP_MUL  = 4'hB
  } op_e;

  localparam int O_IDX = 3;
  localparam int N_IDX = 2;
  localparam int Z_IDX = 1;
  localparam int C_IDX = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_mc_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_mc_if : operand/result handshake bundle between datapath and alu_mc
// Rev 1.0
// ---------------------------------------------------------------------------
interface alu_mc_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       op;
  logic             flag_en;
  logic             flags_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic [3:0]       ONZC;

  modport master (
    output in_valid, A, B, op, flag_en, flags_clr, out_ready,
    input  in_ready, out_valid, Y, ONZC
  );

  modport slave (
    input  in_valid, A, B, op, flag_en, flags_clr, out_ready,
    output in_ready, out_valid, Y, ONZC
  );
endinterface
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_mul_iter : iterative shift-add unsigned multiplier, one bit per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_neg,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o,
  output logic             hi_nz_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = CW'(WIDTH - 1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
      if (cnt_q == '0) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_neg) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // The final product is taken from the accumulator's next value so the
  // owner can register it on the same edge as the last iteration.
  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == '0);
  assign product_o = acc_d[WIDTH-1:0];
  assign hi_nz_o   = |acc_d[2*WIDTH-1:WIDTH];

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_mc : multi-cycle ALU, 12 ops incl. iterative MUL, ONZC flag register
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic    clk,
  input  logic    rst_neg,
  alu_mc_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [3:0]       flags_q, flags_d;
  logic             flag_en_q, flag_en_d;

  logic [WIDTH:0]   sum_w, diff_w;
  logic [WIDTH-1:0] addend_w, alu_y_w, mul_y_w;
  logic [3:0]       alu_f_w, mul_f_w;
  logic             ovf_w, cry_w;
  logic             mul_start_w, mul_busy_w, mul_done_w, mul_hi_nz_w;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_neg   (rst_neg),
    .start_i   (mul_start_w),
    .a_i       (bus.A),
    .b_i       (bus.B),
    .busy_o    (mul_busy_w),
    .done_o    (mul_done_w),
    .product_o (mul_y_w),
    .hi_nz_o   (mul_hi_nz_w)
  );

  // Single-cycle datapath; INC reuses the adder with B forced to +1.
  always_comb begin
    addend_w = (bus.op == OP_INC) ? WIDTH'(1) : bus.B;
    sum_w    = {1'b0, bus.A} + {1'b0, addend_w};
    diff_w   = {1'b0, bus.A} - {1'b0, bus.B};
    alu_y_w  = '0;
    ovf_w    = 1'b0;
    cry_w    = 1'b0;
    case (bus.op)
      OP_ADD, OP_INC: begin
        alu_y_w = sum_w[MSB:0];
        ovf_w   = (bus.A[MSB] == addend_w[MSB]) && (sum_w[MSB] != bus.A[MSB]);
        cry_w   = sum_w[WIDTH];
      end
      OP_SUB: begin
        alu_y_w = diff_w[MSB:0];
        ovf_w   = (bus.A[MSB] != bus.B[MSB]) && (diff_w[MSB] != bus.A[MSB]);
        cry_w   = diff_w[WIDTH];
      end
      OP_AND:  alu_y_w = bus.A & bus.B;
      OP_OR:   alu_y_w = bus.A | bus.B;
      OP_XOR:  alu_y_w = bus.A ^ bus.B;
      OP_MOVA: alu_y_w = bus.A;
      OP_MOVB: alu_y_w = bus.B;
      OP_SHL: begin
        alu_y_w = bus.A << 1;
        cry_w   = bus.A[MSB];
      end
      OP_SHR: begin
        alu_y_w = bus.A >> 1;
        cry_w   = bus.A[0];
      end
      OP_ASR: begin
        alu_y_w = $signed(bus.A) >>> 1;
        cry_w   = bus.A[0];
      end
      default: alu_y_w = '0;
    endcase
    alu_f_w        = '0;
    alu_f_w[O_IDX] = ovf_w;
    alu_f_w[N_IDX] = alu_y_w[MSB];
    alu_f_w[Z_IDX] = (alu_y_w == '0);
    alu_f_w[C_IDX] = cry_w;
    mul_f_w        = '0;
    mul_f_w[N_IDX] = mul_y_w[MSB];
    mul_f_w[Z_IDX] = (mul_y_w == '0);
    mul_f_w[C_IDX] = mul_hi_nz_w;
  end

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    flags_d     = flags_q;
    flag_en_d   = flag_en_q;
    mul_start_w = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          flag_en_d = bus.flag_en;
          if (bus.op == OP_MUL) begin
            state_d     = BUSY;
            mul_start_w = 1'b1;
          end else begin
            state_d = DONE;
            y_d     = alu_y_w;
            if (bus.flag_en) flags_d = alu_f_w;
          end
        end
      end
      BUSY: begin
        if (mul_done_w) begin
          state_d = DONE;
          y_d     = mul_y_w;
          if (flag_en_q) flags_d = mul_f_w;
        end else if (!mul_busy_w) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flags_clr) flags_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_neg) begin
      state_q   <= IDLE;
      y_q       <= '0;
      flags_q   <= '0;
      flag_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      flags_q   <= flags_d;
      flag_en_q <= flag_en_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Y         = y_q;
  assign bus.ONZC      = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_mc : vector table + scoreboard bench for alu_mc (WIDTH=8)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int NV = 20;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         fe;
    logic [W-1:0] y;
    logic [3:0]   f;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] y;
    logic [3:0]   f;
  } exp_t;

  logic clk;
  logic rst_neg;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[NV];

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_neg (rst_neg),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic fe, input logic clr, input logic [W-1:0] ey, input logic [3:0] ef);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.A         = a;
    bus.B         = b;
    bus.flag_en   = fe;
    bus.flags_clr = clr;
    sb_q.push_back({ey, ef});
    tick();
    bus.in_valid  = 1'b0;
    bus.flags_clr = 1'b0;
    bus.flag_en   = 1'b0;
    bus.A         = W'($urandom);
    bus.B         = W'($urandom);
  endtask

  task automatic wait_result(input string name, input int exp_lat);
    int lat    = 1;
    int rdy_hi = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) rdy_hi++;
      tick();
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    if (exp_lat > 1) check({name, "_busy_in_ready"}, 32'(rdy_hi), 32'd0);
    check({name, "_done_in_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  // Scoreboard: every output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_neg && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got output Y=0x%0h, expected none", bus.Y);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_Y", 32'(bus.Y), 32'(mon_e.y));
        check("sb_ONZC", 32'(bus.ONZC), 32'(mon_e.f));
      end
    end
  end

  initial begin
    int bp_bad;
    int ov_cnt;

    vecs[0]  = {OP_ADD,  8'h7F, 8'h01, 1'b1, 8'h80, 4'b1100};
    vecs[1]  = {OP_SUB,  8'h00, 8'h01, 1'b1, 8'hFF, 4'b0101};
    vecs[2]  = {OP_SUB,  8'h00, 8'h01, 1'b0, 8'hFF, 4'b0101};
    vecs[3]  = {OP_MUL,  8'h10, 8'h11, 1'b1, 8'h10, 4'b0001};
    vecs[4]  = {OP_MUL,  8'h03, 8'h05, 1'b1, 8'h0F, 4'b0000};
    vecs[5]  = {OP_ASR,  8'h81, 8'h00, 1'b1, 8'hC0, 4'b0101};
    vecs[6]  = {OP_SHL,  8'h80, 8'h00, 1'b1, 8'h00, 4'b0011};
    vecs[7]  = {OP_AND,  8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000};
    vecs[8]  = {OP_XOR,  8'hFF, 8'h0F, 1'b1, 8'hF0, 4'b0100};
    vecs[9]  = {OP_OR,   8'h0F, 8'h30, 1'b0, 8'h3F, 4'b0100};
    vecs[10] = {OP_INC,  8'h7F, 8'h00, 1'b1, 8'h80, 4'b1100};
    vecs[11] = {OP_INC,  8'hFF, 8'h00, 1'b1, 8'h00, 4'b0011};
    vecs[12] = {OP_MOVA, 8'h55, 8'hAA, 1'b1, 8'h55, 4'b0000};
    vecs[13] = {OP_MOVB, 8'h55, 8'hAA, 1'b1, 8'hAA, 4'b0100};
    vecs[14] = {OP_SHR,  8'h81, 8'h00, 1'b1, 8'h40, 4'b0001};
    vecs[15] = {OP_ADD,  8'hFF, 8'h01, 1'b1, 8'h00, 4'b0011};
    vecs[16] = {OP_SUB,  8'h80, 8'h01, 1'b1, 8'h7F, 4'b1000};
    vecs[17] = {4'hC,    8'h12, 8'h34, 1'b1, 8'h00, 4'b0010};
    vecs[18] = {OP_MUL,  8'hFF, 8'hFF, 1'b1, 8'h01, 4'b0001};
    vecs[19] = {OP_ADD,  8'h80, 8'h80, 1'b1, 8'h00, 4'b1011};

    rst_neg       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.op        = 4'h0;
    bus.flag_en   = 1'b0;
    bus.flags_clr = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst_neg = 1'b1;
    check("rst_Y", 32'(bus.Y), 32'd0);
    check("rst_ONZC", 32'(bus.ONZC), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fe, 1'b0, vecs[i].y, vecs[i].f);
      wait_result($sformatf("v%0d", i), (vecs[i].op == OP_MUL) ? W + 1 : 1);
      tick();
      check($sformatf("v%0d_idle_ready", i), 32'(bus.in_ready), 32'd1);
    end

    // Backpressure: result must hold and new bundles must be ignored.
    bus.out_ready = 1'b0;
    send(OP_ADD, 8'h02, 8'h03, 1'b1, 1'b0, 8'h05, 4'b0000);
    wait_result("bp", 1);
    bp_bad = 0;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'($urandom);
      bus.op       = OP_ADD;
      bus.A        = W'($urandom);
      bus.B        = W'($urandom);
      tick();
      if (bus.Y !== 8'h05 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bp_bad++;
    end
    check("bp_stable", 32'(bp_bad), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    tick();
    check("bp_no_extra_accept", 32'(bus.out_valid), 32'd0);

    // flags_clr on the completion edge of a flag-enabled ADD wins.
    send(OP_ADD, 8'h7F, 8'h01, 1'b1, 1'b0, 8'h80, 4'b1100);
    wait_result("pre_clr", 1);
    tick();
    send(OP_ADD, 8'h7F, 8'h01, 1'b1, 1'b1, 8'h80, 4'b0000);
    wait_result("clr", 1);
    check("clr_ONZC", 32'(bus.ONZC), 32'd0);
    tick();

    // Reset in the middle of a MUL abandons it.
    send(OP_ADD, 8'h7F, 8'h01, 1'b1, 1'b0, 8'h80, 4'b1100);
    wait_result("pre_rst", 1);
    tick();
    send(OP_MUL, 8'h10, 8'h11, 1'b1, 1'b0, 8'h10, 4'b0001);
    tick();
    tick();
    tick();
    rst_neg = 1'b0;
    tick();
    rst_neg = 1'b1;
    sb_q.delete();
    check("mrst_Y", 32'(bus.Y), 32'd0);
    check("mrst_ONZC", 32'(bus.ONZC), 32'd0);
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    ov_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.out_valid) ov_cnt++;
    end
    check("mrst_no_result", 32'(ov_cnt), 32'd0);

    send(OP_MUL, 8'h03, 8'h05, 1'b1, 1'b0, 8'h0F, 4'b0000);
    wait_result("post_rst_mul", W + 1);
    tick();
    check("post_rst_idle", 32'(bus.in_ready), 32'd1);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
